// File: rtl/grid_scan_reader_if.sv
// Read-port and output-stream bundle of the grid scan reader.
// master = scanner side (drives addresses and tuples); slave = RAM/consumer side.
interface grid_scan_reader_if #(
  parameter int COORD_W = 4,
  parameter int VAL_W   = 5
);
  logic               rd_en;
  logic [COORD_W-1:0] rd_cell_x;
  logic [COORD_W-1:0] rd_cell_y;
  logic [VAL_W-1:0]   rd_value;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_cell_x;
  logic [COORD_W-1:0] out_cell_y;
  logic [VAL_W-1:0]   out_value;
  logic               out_last;

  modport master (
    output rd_en, rd_cell_x, rd_cell_y,
    input  rd_value,
    output out_valid, out_cell_x, out_cell_y, out_value, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_cell_x, rd_cell_y,
    output rd_value,
    input  out_valid, out_cell_x, out_cell_y, out_value, out_last,
    output out_ready
  );
endinterface

// File: rtl/grid_scan_reader.sv
// Raster-scans the grid RAM and streams {x, y, value} tuples; first tuple 3 cycles after start.
// Reads are throttled so output + skid registers never overflow under back-pressure.
module grid_scan_reader #(
  parameter int COORD_W = 4,
  parameter int VAL_W   = 5,
  parameter int GRID_W  = 16,  // must be <= 2**COORD_W
  parameter int GRID_H  = 16   // must be <= 2**COORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  grid_scan_reader_if.master    bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VAL_W-1:0]   value;
    logic               last;
  } tuple_t;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic               inflight;
  logic [COORD_W-1:0] tag_x, tag_y;
  logic               out_vld_q, skid_vld;
  tuple_t             out_q, skid_q, ret;
  logic               pop, rd_go, last_addr, kill, room;
  logic [1:0]         occ;

  assign pop       = out_vld_q & bus.out_ready;
  assign occ       = {1'b0, out_vld_q} + {1'b0, skid_vld};
  assign last_addr = (x_cnt == X_MAX) && (y_cnt == Y_MAX);
  assign kill      = abort && (state != IDLE);
  // Issue only if the returning data is guaranteed a free register.
  assign room      = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  assign ret.x     = tag_x;
  assign ret.y     = tag_y;
  assign ret.value = bus.rd_value;
  assign ret.last  = (tag_x == X_MAX) && (tag_y == Y_MAX);

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = SCAN;
      end
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (room) begin
          rd_go = 1'b1;
          if (last_addr) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (occ == 2'd0 && !inflight) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      inflight <= 1'b0;
      tag_x    <= '0;
      tag_y    <= '0;
    end else if (kill) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_go;
      if (rd_go) begin
        tag_x <= x_cnt;
        tag_y <= y_cnt;
        if (x_cnt == X_MAX) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_MAX) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // Skid only ever fills while the output register is stalled, so it drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      skid_vld  <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (kill) begin
      out_vld_q <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (pop) begin
      if (skid_vld) begin
        out_q <= skid_q;
        if (inflight) skid_q   <= ret;
        else          skid_vld <= 1'b0;
      end else if (inflight) begin
        out_q <= ret;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (inflight) begin
      if (out_vld_q) begin
        skid_q   <= ret;
        skid_vld <= 1'b1;
      end else begin
        out_q     <= ret;
        out_vld_q <= 1'b1;
      end
    end
  end

  assign bus.rd_en      = rd_go;
  assign bus.rd_cell_x  = x_cnt;
  assign bus.rd_cell_y  = y_cnt;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_cell_x = out_q.x;
  assign bus.out_cell_y = out_q.y;
  assign bus.out_value  = out_q.value;
  assign bus.out_last   = out_q.last & out_vld_q;

endmodule
